// File: rtl/fft_pkg.sv
// Shared constants, sample/address types, bit-reverse helper and FSM states
// for the FFT bit-reversal reorder stage.
package fft_pkg;

   localparam int N     = 256;
   localparam int LOG2N = 8;
   localparam int WIDTH = 16;

   typedef logic [LOG2N-1:0] idx_t;
   typedef logic [LOG2N:0]   addr_t;

   localparam idx_t IDX_LAST = idx_t'(N - 1);

   typedef struct packed {
      logic [WIDTH-1:0] re;
      logic [WIDTH-1:0] im;
   } cplx_t;

   typedef enum logic [0:0] {
      W_IDLE = 1'b0,
      W_FILL = 1'b1
   } wr_state_e;

   typedef enum logic [1:0] {
      R_IDLE   = 2'd0,
      R_SOF    = 2'd1,
      R_STREAM = 2'd2
   } rd_state_e;

   function automatic idx_t bitrev(input idx_t a);
      idx_t r;
      for (int i = 0; i < LOG2N; i++) begin
         r[i] = a[LOG2N-1-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_bitrev_reorder_if.sv
// Frame stream bundle: bit-reversed input side (vld_in, x_r, x_i) and
// natural-order output side (vld_out, y_r, y_i, dat_vld, frame_drop).
interface fft_bitrev_reorder_if;
   import fft_pkg::*;

   logic             vld_in;
   logic [WIDTH-1:0] x_r;
   logic [WIDTH-1:0] x_i;
   logic             vld_out;
   logic [WIDTH-1:0] y_r;
   logic [WIDTH-1:0] y_i;
   logic             dat_vld;
   logic             frame_drop;

   modport master (
      output vld_in, x_r, x_i,
      input  vld_out, y_r, y_i, dat_vld, frame_drop
   );

   modport slave (
      input  vld_in, x_r, x_i,
      output vld_out, y_r, y_i, dat_vld, frame_drop
   );

endinterface

// File: rtl/fft_reorder_ram.sv
// Ping-pong frame store: 2N words of {re,im}, address {bank, index}.
// One write port, one registered read port; no reset so it maps to block RAM.
module fft_reorder_ram
   import fft_pkg::*;
(
   input  logic  clk,
   input  logic  wr_en,
   input  addr_t wr_addr,
   input  cplx_t wr_data,
   input  logic  rd_en,
   input  addr_t rd_addr,
   output cplx_t rd_data
);

   cplx_t mem_q [2*N];
   cplx_t rd_data_q;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rd_en) begin
         rd_data_q <= mem_q[rd_addr];
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Reorders bit-reversed FFT frames into natural bin order via a ping-pong
// buffer. Ports: clk, rstn (async active-low), io (frame stream slave).
module fft_bitrev_reorder
   import fft_pkg::*;
(
   input  logic                clk,
   input  logic                rstn,
   fft_bitrev_reorder_if.slave io
);

   wr_state_e wr_state_q, wr_state_d;
   idx_t      wr_cnt_q, wr_cnt_d;
   logic      wr_bank_q, wr_bank_d;
   logic      frame_drop_q, frame_drop_d;

   rd_state_e rd_state_q, rd_state_d;
   idx_t      rd_cnt_q, rd_cnt_d;
   logic      rd_bank_q, rd_bank_d;
   logic      pend_q, pend_d;
   logic      pend_bank_q, pend_bank_d;

   logic      frame_rdy;
   logic      ram_we;
   logic      ram_re;
   logic      rd_free;
   addr_t     ram_waddr;
   addr_t     ram_raddr;
   cplx_t     ram_wdata;
   cplx_t     ram_rdata;
   logic      dat_vld;

   // Write side
   always_comb begin
      wr_state_d   = wr_state_q;
      wr_cnt_d     = wr_cnt_q;
      wr_bank_d    = wr_bank_q;
      frame_drop_d = 1'b0;
      frame_rdy    = 1'b0;
      ram_we       = 1'b0;
      unique case (wr_state_q)
         W_IDLE: begin
            if (io.vld_in) begin
               wr_state_d = W_FILL;
               wr_cnt_d   = '0;
            end
         end
         W_FILL: begin
            if (wr_cnt_q == IDX_LAST) begin
               // Last sample completes the frame even if a new
               // start pulse lands in the same cycle.
               ram_we     = 1'b1;
               wr_bank_d  = ~wr_bank_q;
               frame_rdy  = 1'b1;
               wr_cnt_d   = '0;
               wr_state_d = io.vld_in ? W_FILL : W_IDLE;
            end else if (io.vld_in) begin
               // Restart: drop the partial frame, same bank.
               frame_drop_d = 1'b1;
               wr_cnt_d     = '0;
            end else begin
               ram_we   = 1'b1;
               wr_cnt_d = wr_cnt_q + idx_t'(1);
            end
         end
         default: begin
            wr_state_d = W_IDLE;
         end
      endcase
   end

   assign ram_waddr = {wr_bank_q, bitrev(wr_cnt_q)};
   assign ram_wdata = '{re: io.x_r, im: io.x_i};

   // Read side
   assign rd_free = (rd_state_q == R_IDLE) ||
                    ((rd_state_q == R_STREAM) && (rd_cnt_q == '0));

   always_comb begin
      rd_state_d  = rd_state_q;
      rd_cnt_d    = rd_cnt_q;
      rd_bank_d   = rd_bank_q;
      pend_d      = pend_q;
      pend_bank_d = pend_bank_q;
      unique case (rd_state_q)
         R_IDLE: begin
            rd_state_d = R_IDLE;
         end
         R_SOF: begin
            rd_state_d = R_STREAM;
            rd_cnt_d   = rd_cnt_q + idx_t'(1);
         end
         R_STREAM: begin
            // rd_cnt wraps to 0 on the N-th stream cycle.
            rd_cnt_d = rd_cnt_q + idx_t'(1);
            if (rd_cnt_q == '0) begin
               rd_state_d = R_IDLE;
            end
         end
         default: begin
            rd_state_d = R_IDLE;
         end
      endcase
      if (rd_free && (pend_q || frame_rdy)) begin
         // An older pending frame is serviced first; a coincident
         // new one takes its place in the pending slot.
         rd_state_d = R_SOF;
         rd_cnt_d   = '0;
         rd_bank_d  = pend_q ? pend_bank_q : wr_bank_q;
         pend_d     = pend_q && frame_rdy;
         if (frame_rdy) begin
            pend_bank_d = wr_bank_q;
         end
      end else if (frame_rdy) begin
         pend_d      = 1'b1;
         pend_bank_d = wr_bank_q;
      end
   end

   assign ram_re    = (rd_state_q == R_SOF) || (rd_state_q == R_STREAM);
   assign ram_raddr = {rd_bank_q, rd_cnt_q};

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_state_q   <= W_IDLE;
         wr_cnt_q     <= '0;
         wr_bank_q    <= 1'b0;
         frame_drop_q <= 1'b0;
         rd_state_q   <= R_IDLE;
         rd_cnt_q     <= '0;
         rd_bank_q    <= 1'b0;
         pend_q       <= 1'b0;
         pend_bank_q  <= 1'b0;
      end else begin
         wr_state_q   <= wr_state_d;
         wr_cnt_q     <= wr_cnt_d;
         wr_bank_q    <= wr_bank_d;
         frame_drop_q <= frame_drop_d;
         rd_state_q   <= rd_state_d;
         rd_cnt_q     <= rd_cnt_d;
         rd_bank_q    <= rd_bank_d;
         pend_q       <= pend_d;
         pend_bank_q  <= pend_bank_d;
      end
   end

   fft_reorder_ram u_ram (
      .clk     (clk),
      .wr_en   (ram_we),
      .wr_addr (ram_waddr),
      .wr_data (ram_wdata),
      .rd_en   (ram_re),
      .rd_addr (ram_raddr),
      .rd_data (ram_rdata)
   );

   // Stream state lags the issued address by one, matching RAM latency.
   assign dat_vld       = (rd_state_q == R_STREAM);
   assign io.dat_vld    = dat_vld;
   assign io.vld_out    = (rd_state_q == R_SOF);
   assign io.frame_drop = frame_drop_q;
   assign io.y_r        = dat_vld ? ram_rdata.re : '0;
   assign io.y_i        = dat_vld ? ram_rdata.im : '0;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Self-checking bench for fft_bitrev_reorder: cycle-indexed expectation
// model, spot-check tables and hand-written corner sequences.
module tb_fft_bitrev_reorder;
   import fft_pkg::*;

   logic clk;
   logic rstn;
   int   cyc;
   int   n_cmp;
   int   n_bad;

   fft_bitrev_reorder_if io();

   fft_bitrev_reorder dut (
      .clk  (clk),
      .rstn (rstn),
      .io   (io)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Expected output timeline keyed by cycle number
   logic [31:0] exp_y [int];
   bit          exp_sof [int];
   bit          exp_drop [int];

   logic [15:0] in_r [N];
   logic [15:0] in_i [N];
   logic [15:0] cap_r [N];
   logic [15:0] cap_i [N];
   int          cap_idx;
   int          first_dat;
   int          n_drop;
   int          sof_q [$];
   bit          mon_en;
   bit          open_partial;
   int          last_k;

   typedef struct {
      int          id;
      int          bin;
      logic [15:0] er;
      logic [15:0] ei;
   } vec_t;
   vec_t tbl [10];

   function automatic int rev8(input int v);
      int r;
      int t;
      r = 0;
      t = v;
      for (int b = 0; b < 8; b++) begin
         r = r * 2 + t % 2;
         t = t / 2;
      end
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (mon_en && rstn) begin
         logic [31:0] e_y;
         bit e_dv;
         e_dv = exp_y.exists(cyc);
         e_y  = e_dv ? exp_y[cyc] : 32'd0;
         chk("vld_out", {31'd0, io.vld_out}, {31'd0, exp_sof.exists(cyc)});
         chk("dat_vld", {31'd0, io.dat_vld}, {31'd0, e_dv});
         chk("y", {io.y_r, io.y_i}, e_y);
         chk("frame_drop", {31'd0, io.frame_drop},
             {31'd0, exp_drop.exists(cyc)});
         if (io.vld_out) begin
            sof_q.push_back(cyc);
            cap_idx = 0;
         end
         if (io.dat_vld && cap_idx < N) begin
            if (cap_idx == 0) first_dat = cyc;
            cap_r[cap_idx] = io.y_r;
            cap_i[cap_idx] = io.y_i;
            cap_idx++;
         end
         if (io.frame_drop) n_drop++;
      end
   end

   // Pulse now, then nsamp samples; only a full frame produces output.
   task automatic send_frame(input int nsamp);
      int k;
      k = cyc;
      if (open_partial) exp_drop[k+1] = 1'b1;
      if (nsamp == N) begin
         exp_sof[k+N+1] = 1'b1;
         for (int m = 0; m < N; m++) begin
            exp_y[k+N+2+m] = {in_r[rev8(m)], in_i[rev8(m)]};
         end
         last_k = k;
      end
      io.vld_in = 1'b1;
      io.x_r    = '0;
      io.x_i    = '0;
      step();
      io.vld_in = 1'b0;
      for (int j = 0; j < nsamp; j++) begin
         io.x_r = in_r[j];
         io.x_i = in_i[j];
         step();
      end
      io.x_r = '0;
      io.x_i = '0;
      open_partial = (nsamp != N);
   endtask

   task automatic load_ramp(input int off);
      for (int j = 0; j < N; j++) begin
         in_r[j] = 16'(j + off);
         in_i[j] = 16'(-(j + off));
      end
   endtask

   task automatic check_tbl(input int id);
      for (int t = 0; t < 10; t++) begin
         if (tbl[t].id == id) begin
            chk($sformatf("tbl%0d_bin%0d_r", id, tbl[t].bin),
                {16'd0, cap_r[tbl[t].bin]}, {16'd0, tbl[t].er});
            chk($sformatf("tbl%0d_bin%0d_i", id, tbl[t].bin),
                {16'd0, cap_i[tbl[t].bin]}, {16'd0, tbl[t].ei});
         end
      end
   endtask

   initial begin
      int k;
      int s0;
      int d0;
      int nz;

      tbl[0] = '{0, 0,   16'h0000, 16'h0000};
      tbl[1] = '{0, 1,   16'h0080, 16'hFF80};
      tbl[2] = '{0, 2,   16'h0040, 16'hFFC0};
      tbl[3] = '{0, 255, 16'h00FF, 16'hFF01};
      tbl[4] = '{0, 128, 16'h0001, 16'hFFFF};
      tbl[5] = '{1, 128, 16'h0200, 16'h0000};
      tbl[6] = '{1, 0,   16'h0000, 16'h0000};
      tbl[7] = '{1, 1,   16'h0000, 16'h0000};
      tbl[8] = '{1, 64,  16'h0000, 16'h0000};
      tbl[9] = '{1, 255, 16'h0000, 16'h0000};

      n_cmp = 0;
      n_bad = 0;
      cyc = 0;
      cap_idx = 0;
      first_dat = 0;
      n_drop = 0;
      mon_en = 1'b0;
      open_partial = 1'b0;
      last_k = 0;
      io.vld_in = 1'b0;
      io.x_r = '0;
      io.x_i = '0;
      rstn = 1'b1;
      #3 rstn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_vld_out", {31'd0, io.vld_out}, 32'd0);
      chk("rst_dat_vld", {31'd0, io.dat_vld}, 32'd0);
      chk("rst_drop", {31'd0, io.frame_drop}, 32'd0);
      chk("rst_y", {io.y_r, io.y_i}, 32'd0);
      rstn = 1'b1;
      mon_en = 1'b1;
      step();

      // Ramp frame: latency and spot bins
      load_ramp(0);
      send_frame(N);
      k = last_k;
      repeat (N + 8) step();
      chk("ramp_sof_cyc", sof_q[$], k + 257);
      chk("ramp_bin0_cyc", first_dat, k + 258);
      check_tbl(0);

      // Impulse at input index 1
      for (int j = 0; j < N; j++) begin
         in_r[j] = '0;
         in_i[j] = '0;
      end
      in_r[1] = 16'h0200;
      send_frame(N);
      repeat (N + 8) step();
      check_tbl(1);
      nz = 0;
      for (int m = 0; m < N; m++) begin
         if (cap_r[m] != 0 || cap_i[m] != 0) nz++;
      end
      chk("impulse_nonzero_bins", nz, 1);

      // Back-to-back ramp frames, distinct offsets per frame
      s0 = sof_q.size();
      for (int f = 0; f < 3; f++) begin
         load_ramp(1000 * (f + 1));
         send_frame(N);
      end
      repeat (N + 8) step();
      chk("b2b_sof_count", sof_q.size() - s0, 3);
      if (sof_q.size() - s0 == 3) begin
         chk("b2b_period1", sof_q[s0+1] - sof_q[s0], 257);
         chk("b2b_period2", sof_q[s0+2] - sof_q[s0+1], 257);
      end

      // Early restart at sample 100
      d0 = n_drop;
      s0 = sof_q.size();
      load_ramp(7);
      send_frame(100);
      load_ramp(300);
      send_frame(N);
      k = last_k;
      repeat (N + 8) step();
      chk("restart_drop_count", n_drop - d0, 1);
      chk("restart_sof_count", sof_q.size() - s0, 1);
      chk("restart_bin0_cyc", first_dat, k + 258);

      // Randomized frames with random gaps and restarts
      for (int f = 0; f < 6; f++) begin
         for (int j = 0; j < N; j++) begin
            in_r[j] = 16'($urandom);
            in_i[j] = 16'($urandom);
         end
         if ($urandom_range(0, 2) == 0) send_frame($urandom_range(1, N - 2));
         send_frame(N);
         repeat ($urandom_range(0, 4)) step();
      end
      repeat (N + 8) step();

      // Reset during output bin 50
      load_ramp(0);
      send_frame(N);
      k = last_k;
      while (cyc < k + N + 2 + 50) step();
      chk("pre_rst_dat_vld", {31'd0, io.dat_vld}, 32'd1);
      #1 rstn = 1'b0;
      exp_y.delete();
      exp_sof.delete();
      exp_drop.delete();
      open_partial = 1'b0;
      #1;
      chk("mid_rst_vld_out", {31'd0, io.vld_out}, 32'd0);
      chk("mid_rst_dat_vld", {31'd0, io.dat_vld}, 32'd0);
      chk("mid_rst_drop", {31'd0, io.frame_drop}, 32'd0);
      chk("mid_rst_y", {io.y_r, io.y_i}, 32'd0);
      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;
      repeat (300) step();
      s0 = sof_q.size();
      load_ramp(55);
      send_frame(N);
      k = last_k;
      repeat (N + 8) step();
      chk("post_rst_sof_count", sof_q.size() - s0, 1);
      chk("post_rst_bin0_cyc", first_dat, k + 258);

      // Long idle: monitor expects all outputs quiet
      s0 = sof_q.size();
      d0 = n_drop;
      repeat (1000) step();
      chk("idle_sof_count", sof_q.size() - s0, 0);
      chk("idle_drop_count", n_drop - d0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fft_bitrev_reorder.md
# fft_bitrev_reorder

Streaming reorder stage placed directly downstream of the 256-point fixed-point FFT core `fix_fft`. It consumes one complex frame per start-of-frame pulse in the FFT's bit-reversed bin order. It re-emits the same frame in natural bin order (bin 0 first) using a ping-pong frame buffer, so the next frame can be written while the previous one is read. Its output handshake matches the FFT's own frame convention, so it can feed any stage that accepts `fix_fft` output.

## Interface
- `N`, 256, points per frame (power of two).
- `LOG2N`, 8, address width, log2(N).
- `WIDTH`, 16, bits per real/imag component (Q7.9 two's complement, passed through untouched).
- `clk`  in  1  single clock, rising edge.
- `rstn`  in  1  reset, asynchronous assert, active-low.
- `vld_in`  in  1  start-of-frame pulse from FFT `vld_out`; one cycle high.
- `x_r`, `x_i`  in  WIDTH  FFT output sample, bit-reversed order.
- `vld_out`  out  1  start-of-frame pulse, natural order; one cycle high.
- `y_r`, `y_i`  out  WIDTH  reordered sample.
- `dat_vld`  out  1  high exactly during the N cycles carrying `y_r`/`y_i` samples.
- `frame_drop`  out  1  one-cycle pulse when an incomplete input frame is discarded.

## Operation
- Frame convention, input and output identical: pulse in cycle k; samples 0..N-1 in cycles k+1..k+N, one per cycle, no gaps.
- Write side:
  - States: W_IDLE and W_FILL.
  - `vld_in` in W_IDLE moves the block to W_FILL with wr_cnt=0.
  - In W_FILL, sample wr_cnt is written to address bitrev(wr_cnt) of bank wr_bank, then wr_cnt increments.
  - After sample N-1: wr_bank toggles, a frame-ready event is raised to the read side, and the state returns to W_IDLE.
- `vld_in` while in W_FILL: the partial frame is discarded and `frame_drop` pulses the next cycle. The current cycle is treated as a new start pulse (wr_cnt=0), with no bank toggle. A pulse in the same cycle as sample N-1 is legal: it completes the frame and then starts a new one.
- Read side:
  - States: R_IDLE, R_SOF and R_STREAM.
  - A frame-ready event moves R_IDLE to R_SOF: `vld_out`=1 for one cycle, rd_bank = bank just completed, rd_cnt=0.
  - R_STREAM reads address rd_cnt in natural order for N cycles and then returns to R_IDLE.
  - A frame-ready event that arrives while R_STREAM is still running is held pending and serviced the cycle after R_STREAM ends. With ≥1 idle cycle between input frames, no pending event can be overwritten.
- Data is passed bit-exact, with no arithmetic and no width change.
- `y_r`/`y_i` are 0 whenever `dat_vld`=0.

## Timing
- Reset (rstn=0) forces, immediately and asynchronously:
  - all outputs to 0;
  - wr_cnt=0, rd_cnt=0, wr_bank=0;
  - state W_IDLE/R_IDLE;
  - the pending flag cleared.
- RAM contents are not cleared. Reset during any frame abandons it, and no output follows.
- Latency, with `vld_in` in cycle k:
  - last input sample arrives in cycle k+N;
  - `vld_out` pulses in cycle k+N+1;
  - bin m is on `y_r`/`y_i` with `dat_vld`=1 in cycle k+N+2+m.
- The RAM read is registered (1-cycle latency). The read address is issued in R_SOF and each R_STREAM cycle.
- Minimum input frame period is N+1 cycles. Back-to-back input frames give back-to-back output frames with the same period.
- Read and write never address the same bank in the same cycle.

## Structure
- Shared package `fft_pkg`:
  - constants N, LOG2N, WIDTH;
  - function `bitrev(LOG2N-bit)`;
  - write-FSM and read-FSM enum typedefs.
- Sub-module `fft_reorder_ram`: simple dual-port RAM of depth 2N with 2·WIDTH-bit words {re,im}.
  - Address = {bank, index}.
  - One write port, one registered read port, same `clk`.
  - Inferable as block RAM.

## Test plan
- Ramp: input sample j = (x_r=j, x_i=-j).
  - Output bin m = (bitrev(m), -bitrev(m)).
  - Check bin 1 = 128, bin 2 = 64, bin 255 = 255.
  - `vld_out` in cycle k+257; bin 0 in cycle k+258.
- Back-to-back: three ramp frames with 257-cycle period.
  - Three `vld_out` pulses 257 cycles apart.
  - Each frame is reordered correctly with no sample mixing between banks.
- Early restart: `vld_in` at sample 100 of frame 1.
  - `frame_drop` pulses once.
  - Only the restarted frame appears at the output, 258 cycles after the second pulse.
- Reset mid-frame: rstn low at output bin 50 for 3 cycles.
  - All outputs go to 0 at once.
  - No further `dat_vld` until a new complete frame has been written.
- Impulse: x_r=0x0200 (1.0) only at input index 1.
  - Only output bin 128 is nonzero (0x0200).
  - All other bins are 0.
- Idle: no `vld_in` for 1000 cycles.
  - `vld_out`, `dat_vld`, `frame_drop` and `y_r`/`y_i` stay 0.
